// File: rtl/sha1_pad_if.sv
// Byte-in / block-out bundle for the SHA-1 padding front end.
// The master drives bytes and takes blocks; the slave is the padder.
interface sha1_pad_if;
   logic [7:0]   data_in;
   logic         data_valid;
   logic         data_last;
   logic         data_ready;
   logic [511:0] block;
   logic         block_valid;
   logic         block_last;
   logic         block_ready;

   modport master (
      output data_in, data_valid, data_last, block_ready,
      input  data_ready, block, block_valid, block_last
   );

   modport slave (
      input  data_in, data_valid, data_last, block_ready,
      output data_ready, block, block_valid, block_last
   );
endinterface

// File: rtl/sha1_pad.sv
// SHA-1 padder: one byte/cycle in, padded 512-bit blocks out; block_valid 2 cycles after a short tail, 1 after a full block.
// block_ready may stall forever: block/block_last hold, data_ready stays low outside FILL.
module sha1_pad #(
   parameter int CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   sha1_pad_if.slave  bus
);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      PAD    = 2'd1,
      LENBLK = 2'd2,
      EMIT   = 2'd3
   } state_t;

   state_t                 r_state;
   logic [7:0]             r_buf [64];
   logic [5:0]             r_ptr;
   logic [CNT_WIDTH-1:0]   r_len;
   logic                   r_pad_pending;
   logic                   r_pad_marker;
   logic                   r_block_valid;
   logic                   r_block_last;

   logic [63:0]            w_bitlen;
   logic [511:0]           w_block;
   logic                   w_accept;

   assign w_bitlen = 64'(r_len) << 3;
   assign w_accept = (r_state == FILL) && bus.data_valid;

   // Byte b lands in word b/4, first byte of a word in its top lane.
   for (genvar b = 0; b < 64; b++) begin : g_pack
      assign w_block[32*(b/4) + 8*(3 - (b%4)) +: 8] = r_buf[b];
   end

   assign bus.block       = w_block;
   assign bus.block_valid = r_block_valid;
   assign bus.block_last  = r_block_last;
   assign bus.data_ready  = (r_state == FILL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= FILL;
         r_ptr         <= '0;
         r_len         <= '0;
         r_pad_pending <= 1'b0;
         r_pad_marker  <= 1'b0;
         r_block_valid <= 1'b0;
         r_block_last  <= 1'b0;
         for (int i = 0; i < 64; i++) begin
            r_buf[i] <= 8'h00;
         end
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  r_buf[r_ptr] <= bus.data_in;
                  r_ptr        <= r_ptr + 6'd1;
                  r_len        <= r_len + 1'b1;
                  if (bus.data_last) begin
                     if (r_ptr == 6'd63) begin
                        // Ended on a block boundary: the 0x80 marker goes into the length block.
                        r_pad_pending <= 1'b1;
                        r_pad_marker  <= 1'b1;
                        r_block_last  <= 1'b0;
                        r_block_valid <= 1'b1;
                        r_state       <= EMIT;
                     end else begin
                        r_state <= PAD;
                     end
                  end else if (r_ptr == 6'd63) begin
                     r_block_last  <= 1'b0;
                     r_block_valid <= 1'b1;
                     r_state       <= EMIT;
                  end
               end
            end

            PAD: begin
               for (int i = 0; i < 64; i++) begin
                  if (i == int'(r_ptr)) begin
                     r_buf[i] <= 8'h80;
                  end else if (i > int'(r_ptr)) begin
                     if ((r_ptr <= 6'd55) && (i >= 56)) begin
                        r_buf[i] <= w_bitlen[8*(63-i) +: 8];
                     end else begin
                        r_buf[i] <= 8'h00;
                     end
                  end
               end
               if (r_ptr <= 6'd55) begin
                  r_block_last <= 1'b1;
               end else begin
                  r_block_last  <= 1'b0;
                  r_pad_pending <= 1'b1;
                  r_pad_marker  <= 1'b0;
               end
               r_block_valid <= 1'b1;
               r_state       <= EMIT;
            end

            EMIT: begin
               if (bus.block_ready) begin
                  for (int i = 0; i < 64; i++) begin
                     r_buf[i] <= 8'h00;
                  end
                  r_ptr         <= '0;
                  r_block_valid <= 1'b0;
                  r_block_last  <= 1'b0;
                  if (r_block_last) begin
                     r_len   <= '0;
                     r_state <= FILL;
                  end else if (r_pad_pending) begin
                     r_state <= LENBLK;
                  end else begin
                     r_state <= FILL;
                  end
               end
            end

            LENBLK: begin
               for (int i = 0; i < 64; i++) begin
                  if (i >= 56) begin
                     r_buf[i] <= w_bitlen[8*(63-i) +: 8];
                  end else if ((i == 0) && r_pad_marker) begin
                     r_buf[i] <= 8'h80;
                  end else begin
                     r_buf[i] <= 8'h00;
                  end
               end
               r_block_last  <= 1'b1;
               r_pad_pending <= 1'b0;
               r_pad_marker  <= 1'b0;
               r_block_valid <= 1'b1;
               r_state       <= EMIT;
            end

            default: r_state <= FILL;
         endcase
      end
   end

endmodule
